// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit and the control decoder:
// FSM state encoding, opcode values and instruction field bit positions.
package ifu_pkg;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_BIT = 30;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory channel: request (valid/ready + address) and
// in-order response (valid + data, no backpressure).
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  import ifu_pkg::*;

  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rdata;

  modport master (output req_valid, addr, input req_ready, rsp_valid, rdata);
  modport slave  (input req_valid, addr, output req_ready, rsp_valid, rdata);
endinterface

// File: rtl/ifu_fifo.sv
// In-order instruction buffer with flush, occupancy count and a head output
// driven straight from the storage registers (zero while empty).
module ifu_fifo
  import ifu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic                     o_valid,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_valid = (r_count != '0);
  assign o_rdata = o_valid ? r_mem[r_rd_ptr] : '0;
  assign o_count = r_count;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch PC, credit-limited request issue, stale-response dropping on redirect,
// and head-instruction field split. Optional misaligned-target trap: IFU_MISALIGN_TRAP_EN.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 2,
  parameter logic [XLEN-1:0] RESET_PC   = '0
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  instr_fetch_unit_if.master        imem,
  output logic                      o_instr_valid,
  input  logic                      i_instr_ready,
  output logic [XLEN-1:0]           o_instr,
  output logic [XLEN-1:0]           o_instr_pc,
  output logic [6:0]                o_op,
  output logic [2:0]                o_funct3,
  output logic                      o_funct7,
  input  logic                      i_redirect,
  input  logic [XLEN-1:0]           i_redirect_pc,
  output logic                      o_misaligned
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t            r_state;
  logic [XLEN-1:0]   r_fetch_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_cnt;
  logic [CW-1:0]     w_count;
  logic [CW-1:0]     w_inflight_next;
  logic              w_req_valid;
  logic              w_fire;
  logic              w_rsp;
  logic              w_keep;
  logic              w_pop;
  logic              w_misalign;
  logic [XLEN-1:0]   w_redir_pc;
  logic [2*XLEN-1:0] w_head;

  // Buffered plus in-flight words never exceed the buffer size.
  assign w_req_valid = (r_state == S_RUN) &&
                       (({1'b0, w_count} + {1'b0, r_outstanding}) < (CW+1)'(FIFO_DEPTH));
  assign imem.req_valid = w_req_valid;
  assign imem.addr      = r_fetch_pc;

  assign w_fire          = w_req_valid & imem.req_ready;
  assign w_rsp           = imem.rsp_valid;
  assign w_keep          = w_rsp && (r_drop_cnt == '0) && !i_redirect;
  assign w_pop           = o_instr_valid & i_instr_ready;
  assign w_inflight_next = r_outstanding + CW'(w_fire) - CW'(w_rsp);

`ifdef IFU_MISALIGN_TRAP_EN
  assign w_misalign = i_redirect && (i_redirect_pc[1:0] != 2'b00);
  assign w_redir_pc = i_redirect_pc;
`else
  assign w_misalign = 1'b0;
  assign w_redir_pc = {i_redirect_pc[XLEN-1:2], 2'b00};
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_BOOT;
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= w_inflight_next;
      if (i_redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_drop_cnt <= w_inflight_next;
        if (w_misalign) begin
          r_state <= S_HALT;
        end else begin
          r_state    <= S_RUN;
          r_fetch_pc <= w_redir_pc;
        end
      end else begin
        if (w_rsp && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
        if (r_state == S_BOOT) r_state <= S_RUN;
        if (w_fire) r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  logic r_misaligned;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_misaligned <= 1'b0;
    else          r_misaligned <= w_misalign;
  end
  assign o_misaligned = r_misaligned;
`else
  assign o_misaligned = 1'b0;
`endif

  ifu_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_redirect),
    .i_push  (w_keep),
    .i_wdata ({r_fetch_pc_of_rsp(), imem.rdata}),
    .i_pop   (w_pop),
    .o_valid (o_instr_valid),
    .o_rdata (w_head),
    .o_count (w_count)
  );

  // PC of the word now returning: the address issued `outstanding` words ago.
  function automatic logic [XLEN-1:0] r_fetch_pc_of_rsp();
    return r_fetch_pc - XLEN'({r_outstanding, 2'b00});
  endfunction

  assign o_instr    = w_head[XLEN-1:0];
  assign o_instr_pc = w_head[2*XLEN-1:XLEN];
  assign o_op       = o_instr[OP_MSB:OP_LSB];
  assign o_funct3   = o_instr[F3_MSB:F3_LSB];
  assign o_funct7   = o_instr[F7_BIT];

  always @(posedge i_clk) begin
    if (i_rst_n && w_keep)
      assert ((w_count != CW'(FIFO_DEPTH)) || w_pop)
        else $error("ifu: response arrived with instruction buffer full");
  end
endmodule
